// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Logic/arithmetic ops finish in one cycle. Shifts move one
// bit per cycle under a start/busy/done handshake, so the multi-cycle
// controller can stall on busy while a shift is in flight.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1110;
  localparam logic [3:0] OP_SLL = 4'b1111;

  logic [0:0]       state;
  logic [WIDTH-1:0] work;     // partially shifted value
  logic [4:0]       cnt;      // single-bit shifts still to do
  logic             dir_l;    // latched direction: 1 = left

  logic [WIDTH-1:0] op_res;   // one-cycle op result from live inputs
  logic             is_shift;
  logic             is_left;
  logic [WIDTH-1:0] b_sh1;    // first shift step, done at the accepting edge
  logic [WIDTH-1:0] w_sh1;    // next shift step during SHIFT

  assign busy = (state == SHIFT);

  // Single-cycle operation result and first shift step from the request.
  always_comb begin
    op_res   = '0;
    is_shift = (alu_ctl == OP_SLL) || (alu_ctl == OP_SRL);
    is_left  = (alu_ctl == OP_SLL);
    b_sh1    = is_left ? (b << 1) : (b >> 1);
    w_sh1    = dir_l ? (work << 1) : (work >> 1);
    case (alu_ctl)
      OP_ADD: op_res = a + b;
      OP_SUB: op_res = a - b;
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_SLT: op_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: op_res = '0;
    endcase
  end

  // Request acceptance, shift iteration and result/zero/done registration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
      work   <= '0;
      cnt    <= '0;
      dir_l  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!is_shift) begin
              result <= op_res;
              zero   <= (op_res == '0);
              done   <= 1'b1;
            end else if (shamt == 5'd0) begin
              result <= b;
              zero   <= (b == '0);
              done   <= 1'b1;
            end else if (shamt == 5'd1) begin
              // One step total: it completes at the accepting edge.
              result <= b_sh1;
              zero   <= (b_sh1 == '0);
              done   <= 1'b1;
            end else begin
              work  <= b_sh1;
              cnt   <= shamt - 5'd1;
              dir_l <= is_left;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= w_sh1;
            zero   <= (w_sh1 == '0);
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            work <= w_sh1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit. Stimulus pushes hand-computed expected
// results into a scoreboard; a monitor pops and compares on every done pulse.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_ctl = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        zero, busy, done;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_push = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctl(alu_ctl),
    .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      n_done++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: result %h zero %b with no request pending", result, zero);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || zero !== e.z) begin
          n_err++;
          $display("FAIL result_check: got %h/z%b expected %h/z%b", result, zero, e.res, e.z);
        end
      end
    end
  end

  // Present a request once busy is low; optionally keep start high afterwards.
  task automatic issue(input logic [3:0] c, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [4:0] sh, input logic [31:0] er,
                       input bit push, input bit hold);
    int w = 0;
    while (busy && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    if (busy) chk("issue_wait_busy", 32'(busy), 32'd0);
    alu_ctl = c; a = ia; b = ib; shamt = sh; start = 1'b1;
    if (push) begin
      exp_t e;
      e.res = er;
      e.z   = (er == 32'd0);
      sb.push_back(e);
      n_push++;
    end
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_empty(input int max_cyc);
    int w = 0;
    while (sb.size() != 0 && w < max_cyc) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) chk("wait_empty_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Count cycles from the accepting edge to done; cycle 1 is right after it.
  task automatic latency(input string name, input int exp_cyc, input int exp_busy);
    int cyc = 1;
    int bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
    chk({name, "_busy_low_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // add with wrap into the sign bit, never busy
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1, 0);
    chk("add_done", 32'(done), 32'd1);
    chk("add_busy", 32'(busy), 32'd0);
    wait_empty(4);

    issue(4'b0110, 32'h1234, 32'h1234, 5'd0, 32'h0, 1, 0);
    wait_empty(4);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1, 0);
    wait_empty(4);
    issue(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1, 0);
    wait_empty(4);

    // shamt 0 and 1 both complete in one cycle
    issue(4'b1111, 32'h0, 32'h0000_ABCD, 5'd0, 32'h0000_ABCD, 1, 0);
    latency("sll0", 1, 0);
    wait_empty(4);
    issue(4'b1110, 32'h0, 32'h0000_0001, 5'd1, 32'h0, 1, 0);
    latency("srl1", 1, 0);
    wait_empty(4);

    issue(4'b1111, 32'h0, 32'h1, 5'd5, 32'h20, 1, 0);
    latency("sll5", 5, 4);
    wait_empty(4);
    issue(4'b1110, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 1, 0);
    latency("srl31", 31, 30);
    wait_empty(4);

    // start while busy is ignored and inputs are free to change
    issue(4'b1111, 32'h0, 32'h3, 5'd10, 32'h0000_0C00, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    alu_ctl = 4'b0010; a = 32'd5; b = 32'd7; shamt = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_busy_held", 32'(busy), 32'd1);
    wait_empty(20);
    @(posedge clk); #1;
    chk("ignore_no_extra", 32'(n_done), 32'(n_push));

    // reset mid-shift aborts without a done pulse
    issue(4'b1111, 32'h0, 32'h1, 5'd20, 32'h0, 0, 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_done", 32'(done), 32'd0);

    // reset beats start
    reset = 1'b1; alu_ctl = 4'b0010; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start_done", 32'(done), 32'd0);
    chk("rst_start_result", result, 32'd0);

    issue(4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1, 0);
    wait_empty(4);

    // back-to-back one-cycle ops with start held high
    issue(4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F, 1, 1);
    chk("b2b_done_and", 32'(done), 32'd1);
    issue(4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFFF0_0FFF, 1, 1);
    chk("b2b_done_or", 32'(done), 32'd1);
    issue(4'b1010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h0, 1, 0);
    chk("b2b_done_undef", 32'(done), 32'd1);
    wait_empty(4);

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with the register operands and shift amount. Logic/arithmetic ops complete in one cycle. Shifts are performed iteratively, one bit per cycle, under a start/busy/done handshake. The handshake lets the multi-cycle datapath controller stall while a shift is in progress.

## Interface
- WIDTH, 32, datapath width in bits; must be 32 for MIPS shift semantics.
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start  input  1  request pulse; sampled only when busy=0.
- alu_ctl  input  4  operation code from ALU control decoder.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt or sign-extended immediate); shift source.
- shamt  input  5  shift amount (instruction bits 10:6).
- result  output  WIDTH  registered result of last completed operation.
- zero  output  1  registered flag; 1 when result == 0.
- busy  output  1  1 while a shift is iterating; start ignored while high.
- done  output  1  one-cycle pulse in the cycle result/zero first show a new value.

## Operation
- Opcodes:
  - 0010 add: a+b, wraps mod 2^32, no overflow trap.
  - 0110 sub: a-b, wraps.
  - 0000 and: a&b.
  - 0001 or: a|b.
  - 0111 slt: signed compare, result = 32'd1 if $signed(a) < $signed(b), else 0.
  - 1111 sll: b << shamt, zero fill.
  - 1110 srl: b >> shamt, zero fill (logical).
  - Any other code: result 0, completes as a one-cycle op.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- IDLE, start=1:
  - Non-shift op: result, zero and done=1 are registered at that edge; stay in IDLE.
  - Shift with shamt=0: result=b, done=1 at that edge; stay in IDLE.
  - Shift with shamt=k≥1: the edge loads working reg = b shifted by 1 and count = k-1.
    - If count = 0, complete at that edge.
    - Otherwise go to SHIFT.
- SHIFT: each edge shifts working reg by 1 in the latched direction and decrements count.
  - The edge at which count reaches 0 writes result/zero, pulses done and returns to IDLE.
- Operands, alu_ctl and shamt are latched at the accepting edge. Input changes during SHIFT have no effect.
- result/zero hold their last value until the next completion. They are not updated during SHIFT iterations.

## Timing
- Reset values: result=0, zero=1, busy=0, done=0, state=IDLE, count=0.
- Latency, with start accepted at edge N: done is high in the cycle after edge N+L-1, where:
  - L = 1 for non-shift ops and shamt=0.
  - L = shamt for shamt≥1. Max L = 31.
- busy rises after the accepting edge when L>1. It falls after the completing edge, in the same cycle done is high.
- done is high for exactly one cycle per accepted start. No done without an accepted start.
- start while busy=1: ignored; no queueing; in-flight op unaffected.
- start=1 in the cycle done=1: busy=0 there, so the new op is accepted (back-to-back throughput of 1 op/cycle for one-cycle ops).
- Reset asserted mid-SHIFT: at that edge return to IDLE and load reset values. No done pulse for the aborted op.
- reset and start high together: reset wins; start is dropped.
- zero is computed from the value being written to result, in the same edge.

## Test plan
- add a=32'h7FFFFFFF, b=1 -> next cycle result=32'h80000000, zero=0, done=1 for 1 cycle, busy never high.
- sub a=b=32'h1234 -> result=0, zero=1 after 1 cycle. Then slt a=32'hFFFFFFFF, b=1 -> result=1. slt a=1, b=32'hFFFFFFFF -> result=0.
- sll b=32'h1, shamt=5 -> busy high 4 cycles, done in 5th cycle, result=32'h20. srl b=32'h80000000, shamt=31 -> done after 31 cycles, result=1.
- Start sll shamt=10; at cycle 3 pulse start with add and change a/b/shamt -> add ignored, result=b<<10 of the original b, exactly one done.
- sll shamt=20, assert reset at cycle 7 -> next cycle busy=0, result=0, zero=1, no done pulse. Then add 2+3 -> result=5.
- Back-to-back: start held high with and, or, undefined 4'b1010 on consecutive cycles -> three consecutive done pulses, results a&b, a|b, 0.
